spi_pwm_bank: RTL
=================

Name: spi_pwm_bank

Overview:
Parametrised successor to the team's fixed 7-channel SPI PWM driver. It provides CHANNELS PWM outputs of WIDTH-bit resolution, all configured over a mode-0 SPI slave. New over the previous generation:
- all channels writable
- programmable period (TOP)
- double-buffered registers, applied at the period boundary
- burst auto-increment access
- period-start strobe

It sits directly behind the chip pins, with SPI inputs asynchronous to clk.

Parameters:
CHANNELS, 7, number of PWM outputs (1..64).
WIDTH, 8, PWM counter, level and TOP width in bits (4..16).

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
sclk  input  1  SPI clock, asynchronous, mode 0, frequency <= clk/8.
cs_n  input  1  SPI chip select, active low, asynchronous.
mosi  input  1  SPI data in, MSB first.
miso  output  1  SPI data out, MSB first, registered.
pwm_out  output  CHANNELS  PWM outputs, registered.
period_start  output  1  one-cycle strobe on the first cycle of each PWM period, registered.

Behaviour:
- Reset is asynchronous, active-low; one clock; reset is asynchronous and active-low.
- Reset values:
  - pwm_out=0, miso=0, period_start=0, counter=0.
  - All shadow and active levels = 0.
  - Shadow and active TOP = 2^WIDTH-2 (255-cycle period at WIDTH=8).
  - SPI state idle.
  - Reset mid-frame aborts the frame; no register write.
- Input synchronisation:
  - sclk, cs_n and mosi each pass through a 2-flop synchroniser.
  - SPI edges are detected on synchronised sclk.
  - mosi is sampled on a rising edge; miso updates on a falling edge.
- Frame format (cs_n low):
  - 8-bit command, then one or more WIDTH-bit data words.
  - Command bit7 = write(1)/read(0); bit6 = space (0 = channel levels, 1 = control); bits5:0 = start address.
- Control space:
  - addr 0 = TOP (read/write).
  - addr 1 = ID (read-only): returns CHANNELS zero-extended to WIDTH.
  - Other addresses read 0; writes to them are ignored.
- Channel space: addr >= CHANNELS reads 0; writes to it are ignored.
- Write path:
  - Each data word is committed to the shadow register on the clk cycle after its last (WIDTH-th) rising sclk edge is detected.
  - Address then increments by 1 (6-bit wrap 63->0) for the next word.
  - A partial word when cs_n rises is discarded.
- Read path:
  - Data for the current address loads into the shift register on the falling edge after the command's 8th rising edge (and after each word's last bit).
  - miso presents the MSB on that edge and shifts on each later falling edge.
  - Reads return shadow values; address auto-increments per word.
  - miso is forced to 0 while cs_n (synchronised) is high.
- cs_n rising at any point returns SPI to idle and clears its bit counter. A new frame starts at the next cs_n fall.
- PWM counter:
  - Counts 0..active TOP inclusive, then wraps to 0; period = TOP+1 cycles.
  - On the wrap edge (and on the first edge after reset release), active TOP and all active levels load from shadow.
- Write coinciding with wrap:
  - Active registers take the pre-edge shadow value.
  - The new value lands in the shadow only and applies from the following period.
- Outputs and period timing:
  - period_start is high exactly in the first output cycle of each period.
  - pwm_out[i] is high for the first min(L_i, TOP+1) cycles of each period, starting at that cycle, then low.
  - L=0: output always low.
  - L >= TOP+1: output always high.
- TOP=0: period is 1 cycle; period_start is held high continuously; pwm_out[i] = (L_i != 0).
- Reducing TOP below the current counter value has no mid-period effect: the new TOP takes effect only at the next wrap.

Test Plan:
1. Reset release, no SPI activity -> all pwm_out low; period_start pulses every 255 clk (WIDTH=8).
2. Write ch3=0x40 (cmd 0x83, data 0x40) mid-period -> ch3 stays low until the next period_start, then high for 64 of every 255 cycles; other channels stay low.
3. Burst write: cmd 0x80, data 0x01,0xFE,0xFF for ch0..2 -> duty ch0 1/255, ch1 254/255, ch2 always high; read back with cmd 0x00 returns 0x01,0xFE,0xFF on miso.
4. Write TOP=9 (cmd 0xC0, data 0x09); ch0 level 5 -> from the next boundary, period 10 cycles, ch0 high 5 of 10; ch0 level 12 -> continuously high.
5. Read ID (cmd 0x41) -> miso returns 0x07; read cmd 0x07 (unimplemented channel 7) -> 0x00; write to addr 7 leaves every channel unchanged.
6. cs_n raised after 4 data bits of a write; separately, reset_n pulsed mid-frame -> no register change; reset_n asynchronously clears pwm_out and miso; the next full frame decodes correctly.

Source files
------------

// File: rtl/spi_pwm_bank.sv
// Bank of CHANNELS double-buffered PWM outputs configured through a mode-0 SPI slave.
// Shadow registers are written over SPI; active copies reload at every period wrap.

module spi_pwm_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             load,
    input  logic [WIDTH-1:0] cnt_nxt,
    output logic [WIDTH-1:0] shadow,
    output logic             pwm
);
    logic [WIDTH-1:0] active;

    // On a wrap edge the output already reflects the level being loaded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wr_en) shadow <= wr_data;
            if (load)  active <= shadow;
            pwm <= cnt_nxt < (load ? shadow : active);
        end
    end
endmodule

module spi_pwm_bank #(
    parameter int CHANNELS = 7,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sclk,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);
    localparam int SW = (WIDTH > 8) ? WIDTH : 8;
    localparam int CW = $clog2(SW);
    localparam logic [WIDTH-1:0] TOP_RST   = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [CW-1:0]    CMD_LAST  = CW'(7);
    localparam logic [CW-1:0]    WORD_LAST = CW'(WIDTH-1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} spi_state_t;

    typedef struct packed {
        logic             space;
        logic [5:0]       addr;
        logic [WIDTH-1:0] data;
    } wr_req_t;

    logic [2:0] sclk_q, cs_q;
    logic [1:0] mosi_q;
    logic       sclk_rise, sclk_fall, cs_sync, cs_fall, mosi_sync;

    spi_state_t           state, state_nxt;
    logic                 cmd_done, word_done;
    logic [CW-1:0]        bit_cnt;
    logic [SW-2:0]        shift_in;
    logic [WIDTH-1:0]     word_in, tx, rd_data;
    logic                 cmd_wr, cmd_space, load_pend, wr_pend;
    logic [5:0]           addr;
    wr_req_t              wr_req;

    logic [CHANNELS-1:0][WIDTH-1:0] shadow_lvl;
    logic [WIDTH-1:0]     shadow_top, active_top, cnt, cnt_nxt;
    logic                 started, wrap;

    // cs history resets low so a frame in flight across reset is ignored until cs_n toggles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[1:0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_sync   = cs_q[1];
    assign cs_fall   = cs_q[2] & ~cs_q[1];
    assign mosi_sync = mosi_q[1];
    assign word_in   = {shift_in[WIDTH-2:0], mosi_sync};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_done  = 1'b0;
        word_done = 1'b0;
        if (cs_sync) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (cs_fall) state_nxt = S_CMD;
                S_CMD: if (sclk_rise && bit_cnt == CMD_LAST) begin
                    cmd_done  = 1'b1;
                    state_nxt = S_DATA;
                end
                S_DATA: if (sclk_rise && bit_cnt == WORD_LAST) word_done = 1'b1;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (cmd_space) begin
            if (addr == 6'd0)      rd_data = shadow_top;
            else if (addr == 6'd1) rd_data = WIDTH'(CHANNELS);
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                if (addr == 6'(i)) rd_data = shadow_lvl[i];
        end
    end

    // Completed words are queued for one cycle and committed on the following edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            cmd_wr    <= 1'b0;
            cmd_space <= 1'b0;
            addr      <= '0;
            load_pend <= 1'b0;
            wr_pend   <= 1'b0;
            wr_req    <= '0;
            tx        <= '0;
            miso      <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (cs_sync) begin
                bit_cnt   <= '0;
                load_pend <= 1'b0;
                tx        <= '0;
                miso      <= 1'b0;
            end else begin
                if (sclk_rise && state != S_IDLE) begin
                    shift_in <= {shift_in[SW-3:0], mosi_sync};
                    bit_cnt  <= (cmd_done || word_done) ? '0 : bit_cnt + 1'b1;
                end
                if (cmd_done) begin
                    cmd_wr    <= shift_in[6];
                    cmd_space <= shift_in[5];
                    addr      <= {shift_in[4:0], mosi_sync};
                    load_pend <= 1'b1;
                end
                if (word_done) begin
                    wr_pend   <= cmd_wr;
                    wr_req    <= '{space: cmd_space, addr: addr, data: word_in};
                    addr      <= addr + 1'b1;
                    load_pend <= 1'b1;
                end
                if (sclk_fall) begin
                    if (load_pend) begin
                        miso      <= rd_data[WIDTH-1];
                        tx        <= rd_data << 1;
                        load_pend <= 1'b0;
                    end else begin
                        miso <= tx[WIDTH-1];
                        tx   <= tx << 1;
                    end
                end
            end
        end
    end

    assign wrap    = !started || (cnt == active_top);
    assign cnt_nxt = wrap ? '0 : cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started      <= 1'b0;
            cnt          <= '0;
            active_top   <= TOP_RST;
            shadow_top   <= TOP_RST;
            period_start <= 1'b0;
        end else begin
            started      <= 1'b1;
            cnt          <= cnt_nxt;
            period_start <= wrap;
            if (wrap) active_top <= shadow_top;
            if (wr_pend && wr_req.space && wr_req.addr == 6'd0) shadow_top <= wr_req.data;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        spi_pwm_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (wr_pend && !wr_req.space && wr_req.addr == 6'(i)),
            .wr_data (wr_req.data),
            .load    (wrap),
            .cnt_nxt (cnt_nxt),
            .shadow  (shadow_lvl[i]),
            .pwm     (pwm_out[i])
        );
    end
endmodule
